// File: rtl/q5_vector_checker.sv
// Stimulus/response checker for the Q5 sequential circuit: plays an 8-step vector table
// into the behavioral and structural Q5 copies and scores their outputs. Optional: Q5_STOP_ON_ERR_EN.
module q5_vector_checker #(
    parameter int HOLD_CYCLES = 20,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       X1,
    output logic       X2,
    input  logic       Zb1,
    input  logic       Zb2,
    input  logic       Zs1,
    input  logic       Zs2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_err,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_HOLD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       vec_cur;
    logic [1:0]       exp_z;
    logic             mismatch;

    // {X1,X2,Z1,Z2} for each step
    function automatic logic [3:0] vec_tab(input logic [2:0] s);
        case (s)
            3'd0:    vec_tab = 4'b00_00;
            3'd1:    vec_tab = 4'b01_00;
            3'd2:    vec_tab = 4'b11_11;
            3'd3:    vec_tab = 4'b01_10;
            3'd4:    vec_tab = 4'b00_10;
            3'd5:    vec_tab = 4'b10_01;
            3'd6:    vec_tab = 4'b11_00;
            default: vec_tab = 4'b01_00;
        endcase
    endfunction

    assign vec_cur = vec_tab(step);
    assign exp_z   = vec_cur[1:0];

    // Case inequality makes an X/Z on any DUT output count as a failure in simulation.
`ifdef SYNTHESIS
    assign mismatch = ({Zb1, Zb2} != exp_z) || ({Zs1, Zs2} != exp_z);
`else
    assign mismatch = ({Zb1, Zb2} !== exp_z) || ({Zs1, Zs2} !== exp_z);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_APPLY;
            S_APPLY: state_nx = S_HOLD;
            S_HOLD:  if (cnt == '0) state_nx = S_CHECK;
            S_CHECK: begin
                if (step == 3'd7) state_nx = S_DONE;
                else              state_nx = S_APPLY;
`ifdef Q5_STOP_ON_ERR_EN
                if (mismatch) state_nx = S_DONE;
`endif
            end
            S_DONE:  if (start) state_nx = S_APPLY;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            X1        <= 1'b0;
            X2        <= 1'b0;
            cnt       <= '0;
            err_count <= 4'd0;
            first_err <= 3'd0;
            step      <= 3'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count <= 4'd0;
                        first_err <= 3'd0;
                        step      <= 3'd0;
                    end
                end
                S_APPLY: begin
                    X1  <= vec_cur[3];
                    X2  <= vec_cur[2];
                    cnt <= CNT_W'(HOLD_CYCLES - 1);
                end
                S_HOLD: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count == 4'd0) first_err <= step;
                        if (err_count != 4'd15) err_count <= err_count + 4'd1;
                    end
                    // step advances only when another vector follows, so it parks on the last one checked
                    if (state_nx == S_APPLY) step <= step + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_APPLY) || (state == S_HOLD) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 4'd0);

endmodule
